// File: rtl/uart_echo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_ctrl_pkg
// Purpose  : Shared types and constants for the UART echo/host TX sequencer:
//            FSM state encoding, grant-source encoding and the round-robin
//            arbitration helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_echo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  localparam logic GRANT_ECHO = 1'b0;
  localparam logic GRANT_HOST = 1'b1;

  // Round-robin between two requesters: when both are ready, the one that
  // did not win last time gets the grant.
  function automatic logic pick_grant(input logic echo_rdy,
                                      input logic host_rdy,
                                      input logic last_grant);
    if (echo_rdy && host_rdy) begin
      return ~last_grant;
    end else if (host_rdy) begin
      return GRANT_HOST;
    end else begin
      return GRANT_ECHO;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_fifo
// Purpose  : Small byte FIFO buffering received bytes for echo. Reads are
//            show-ahead (dout valid whenever not empty). A push while full
//            is accepted only if a pop happens in the same cycle.
// Ports    : clk, rst (async, active-low), push_i/din_i write side,
//            pop_i/dout_o read side, level_o occupancy, full_o, empty_o.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          w_push, w_pop;

  assign full_o  = (level_q == FULL_LEVEL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pop never underflows; a full FIFO accepts a push only when a slot is
  // being freed in the same cycle.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only observed when level != 0.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_echo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_ctrl
// Purpose  : Shares one UART transmitter between the echo path (bytes from
//            the UART receiver, buffered in a FIFO) and a host byte source.
//            Round-robin arbitration, tx_val/tx_busy launch handshake and a
//            start timeout that aborts a launch the transmitter never takes.
// Ports    : clk, rst (async, active-low)
//            echo_en, rx_val, rx_data           - receive/echo side
//            host_req, host_data, host_ack      - host byte source
//            tx_busy, tx_val, tx_data, grant_src - transmitter handshake
//            fifo_level, ovf, timeout_err       - status
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_ctrl
  import uart_echo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         echo_en,
  input  logic                         rx_val,
  input  logic [7:0]                   rx_data,
  input  logic                         host_req,
  input  logic [7:0]                   host_data,
  output logic                         host_ack,
  input  logic                         tx_busy,
  output logic                         tx_val,
  output logic [7:0]                   tx_data,
  output logic                         grant_src,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         ovf,
  output logic                         timeout_err
);

  localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(START_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          grant_src_q, grant_src_d;
  logic          last_grant_q, last_grant_d;

  logic          w_pop, w_push, w_sel, w_host_ack;
  logic          w_echo_rdy, w_host_rdy;
  logic [7:0]    w_fifo_dout;
  logic          w_fifo_full, w_fifo_empty;

  assign w_push = rx_val & echo_en;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (rx_data),
    .dout_o  (w_fifo_dout),
    .level_o (fifo_level),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Buffered bytes are held, not arbitrated, while echo is disabled.
  assign w_echo_rdy = ~w_fifo_empty & echo_en;
  assign w_host_rdy = host_req;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    grant_src_d  = grant_src_q;
    last_grant_d = last_grant_q;
    w_sel        = GRANT_ECHO;
    w_pop        = 1'b0;
    w_host_ack   = 1'b0;
    timeout_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A busy transmitter blocks every grant, whoever made it busy.
        if (!tx_busy && (w_echo_rdy || w_host_rdy)) begin
          w_sel        = pick_grant(w_echo_rdy, w_host_rdy, last_grant_q);
          state_d      = ST_LAUNCH;
          cnt_d        = '0;
          grant_src_d  = w_sel;
          last_grant_d = w_sel;
          if (w_sel == GRANT_ECHO) begin
            tx_data_d = w_fifo_dout;
            w_pop     = 1'b1;
          end else begin
            tx_data_d  = host_data;
            w_host_ack = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          // Transmitter never accepted the byte: drop it, no retry.
          timeout_err = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      grant_src_q  <= 1'b0;
      last_grant_q <= GRANT_HOST;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      grant_src_q  <= grant_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  // tx_val is decoded from the state so it drops the moment reset asserts.
  assign tx_val    = (state_q == ST_LAUNCH);
  assign tx_data   = tx_data_q;
  assign grant_src = grant_src_q;
  // The grant decision is combinational; qualify the ack so it stays low
  // while reset is held even if host_req is already high.
  assign host_ack  = w_host_ack & rst;
  assign ovf       = w_push & w_fifo_full & ~w_pop;

endmodule
`default_nettype wire
